// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode constants, instruction classes, encoder states.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Values 5..7 are not members and are treated as illegal classes.
  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } inst_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/rv_inst_pack.sv
// Combinational RV32I packer: class + decoded fields in, 32-bit word and illegal flag out.
module rv_inst_pack
  import rv_pkg::*;
(
  input  logic [2:0]  i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_alt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [12:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Assemble the instruction word for the selected class.
  always_comb begin
    o_word    = 32'h0000_0000;
    o_illegal = 1'b0;
    case (inst_class_e'(i_class))
      CLS_R: begin
        o_word = {(i_alt ? 7'b0100000 : 7'b0000000), i_rs2, i_rs1, i_funct3, i_rd, OP_R};
      end
      CLS_I: begin
        // Shift-immediates carry funct7 in imm[11:5]; only the SRAI bit is user controlled.
        if ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) begin
          o_word = {1'b0, i_alt, 5'b00000, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_IMM};
        end else begin
          o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM};
        end
      end
      CLS_LOAD: begin
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
      end
      CLS_STORE: begin
        o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
      end
      CLS_BRANCH: begin
        // Branch offsets are halfword aligned, so imm[0] never reaches the word.
        o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], OP_BRANCH};
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv_inst_encoder.sv
// Streaming RV32I encoder / instruction-memory loader with a single output register.
module rv_inst_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  enc_state_e        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_data;
  logic              r_err;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_in_ready;
  logic        w_accept;

  rv_inst_pack u_pack (
    .i_class   (in_class),
    .i_funct3  (in_funct3),
    .i_alt     (in_alt),
    .i_rd      (in_rd),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // The output register refills in the same cycle it drains; a start cycle never accepts.
  assign w_in_ready = (r_state == ST_LOAD) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready && !start;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign count     = r_count;
  assign full      = (r_state == ST_FULL);
  assign err       = r_err;

  // Session FSM, address pointer, word counter and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= BASE_PTR;
      r_count     <= {(ADDR_W+1){1'b0}};
      r_out_valid <= 1'b0;
      r_out_addr  <= {ADDR_W{1'b0}};
      r_out_data  <= 32'h0000_0000;
      r_err       <= 1'b0;
    end else if (start) begin
      r_state     <= ST_LOAD;
      r_ptr       <= BASE_PTR;
      r_count     <= {(ADDR_W+1){1'b0}};
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_word;
              r_out_addr  <= r_ptr;
              r_count     <= r_count + CNT_ONE;
              // The last address parks the loader instead of wrapping onto word 0.
              if (r_ptr == LAST_PTR) begin
                r_state <= ST_FULL;
              end else begin
                r_ptr <= r_ptr + PTR_ONE;
              end
            end
          end
          if (stop) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_FULL: begin
          r_state <= ST_FULL;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rv_inst_encoder.md
# rv_inst_encoder

Streaming RV32I instruction encoder and instruction-memory loader. It accepts decoded instruction fields over a valid/ready input and packs them into 32-bit words. These cover the same five classes the control unit decodes: R-type, I-type ALU, load, store and branch. Each word is emitted on a valid/ready memory-write port with an auto-incrementing word address. It is the producer side of the opcode path: self-tests and boot programs load instruction memory through it, and the control unit then consumes those words.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, first word address after `start`
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse: restart load at BASE_ADDR, clear err/count, drop held word
- stop  in  1  pulse: end load session; the held word still drains
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_class  in  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5–7 illegal
- in_funct3  in  3  funct3
- in_alt  in  1  funct7[5] (SUB/SRA/SRAI)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  13  immediate; bits [11:0] for I/LOAD/STORE, [12:1] for BRANCH
- out_valid  out  1  encoded word held
- out_ready  in  1  memory accepts word
- out_addr  out  ADDR_W  word address
- out_data  out  32  encoded instruction
- count  out  ADDR_W+1  legal words accepted this session
- full  out  1  address space exhausted
- err  out  1  sticky: illegal class seen this session

## Operation
- States: IDLE, LOAD, FULL. Reset: state IDLE, ptr=BASE_ADDR, and all outputs 0 (out_addr=0, out_data=0, count=0).
- IDLE: in_ready=0. `start` moves to LOAD.
- LOAD: in_ready = !out_valid || out_ready, so there is a single output register with pass-through refill.
- `stop` in LOAD moves to IDLE. `start` in any state moves to LOAD. If both are asserted, `start` wins.
- Accepting a legal bundle:
  - out_data takes the encoded word and out_addr takes ptr; out_valid=1.
  - ptr and count each increment by 1.
- Accepting an illegal class (5–7):
  - The bundle is consumed and err is set.
  - No word is produced and ptr/count are unchanged.
- Encodings, as MSB..LSB concatenations:
  - R: alt?0100000:0000000 | rs2 | rs1 | f3 | rd | 0110011.
  - I-ALU: imm[11:0] | rs1 | f3 | rd | 0010011.
  - I-ALU when f3 is 001 or 101: imm[11:5] is forced to {0, alt, 00000}.
  - LOAD: imm[11:0] | rs1 | f3 | rd | 0000011.
  - STORE: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | 0100011.
  - BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | 1100011. imm[0] is ignored.
  - Register fields that an encoding does not use are ignored.
- Wrap-around:
  - When the word at address 2^ADDR_W−1 is accepted, the state moves to FULL: full=1, in_ready=0, and ptr is held, not wrapped.
  - The held word still drains. count saturates at 2^ADDR_W.
- `start` mid-session discards the held word (out_valid=0 next cycle) and reloads ptr.
- `rst` mid-transfer returns everything to reset values immediately.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N appears on out_* after edge N.
- Throughput is 1 word/cycle while out_ready=1.
- out_data and out_addr are stable while out_valid && !out_ready.
- out_valid drops after the edge where out_ready is sampled high, unless a new bundle is accepted on that same edge.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid to out_*.
- `start` and `stop` take effect at the next edge. A bundle presented in the `start` cycle is not accepted.

## Structure
- Package rv_pkg, shared with the control unit, holds:
  - the opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - the typedef enum inst_class_e;
  - the state enum enc_state_e.
- Combinational sub-module rv_inst_pack: class + fields in, 32-bit word and illegal flag out.
- The top level holds the FSM, ptr/count and the output register.

## Test plan
- Reset, then start:
  - in_ready=1 and out_valid=0.
  - R, alt=0, rd=3, rs1=1, rs2=2, f3=0 → out_data 0x002081B3 @0.
  - Same with alt=1 → 0x402081B3 @1.
- I, LOAD and shift encodings:
  - I-ALU rd=1, rs1=0, imm=5 → 0x00500093.
  - LOAD rd=5, rs1=2, f3=2, imm=8 → 0x00812283.
  - I-ALU f3=5, alt=1, rd=1, rs1=1, imm=3 → 0x4030D093.
- STORE and BRANCH encodings:
  - STORE rs2=5, rs1=2, f3=2, imm=12 → 0x00512623.
  - BRANCH rs1=1, rs2=2, f3=0, imm=−4 (0x1FFC) → 0xFE208EE3.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1. Then in_ready=0, out_data/out_addr are stable and only 1 word is accepted.
  - Release out_ready and continue back-to-back: addresses are contiguous and no words are dropped or duplicated.
- Illegal class:
  - A class-6 bundle between two legal bundles sets err=1.
  - The legal words land at consecutive addresses and count=2.
  - `start` clears err.
- Full and control pulses (ADDR_W=2):
  - After 4 words, full=1, in_ready=0 and count=4. The 4th word at address 3 drains.
  - `start` mid-stream drops the held word and the next word lands at address 0.
  - `stop` returns to IDLE.
  - Asserting rst mid-transfer zeroes all outputs asynchronously.
